// File: rtl/rv_shift_fifo_pkg.sv
// Shared helpers for rv_shift_fifo and its occupancy controller.
// Optional feature macro used by the top: RV_SHIFT_FIFO_BYPASS_EN.
package rv_shift_fifo_pkg;

    // Smallest legal FIFO depth; a one-entry shift FIFO has no read index to track.
    localparam int MIN_DEPTH = 2;

    // Width of an index into an array of 'depth' entries, never less than 1.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rv_shift_fifo_ctrl.sv
// Occupancy counter with registered empty/full flags for shift-register queues.
// push and pop must already be qualified by the caller (no push while full,
// no pop while empty).
module rv_shift_fifo_ctrl
    import rv_shift_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SIZEW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    output logic [SIZEW-1:0] size,
    output logic             empty,
    output logic             full
);

    logic [SIZEW-1:0] size_nxt;

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        size_nxt = size;
        case ({push, pop})
            2'b10:   size_nxt = size + SIZEW'(1);
            2'b01:   size_nxt = size - SIZEW'(1);
            default: size_nxt = size;
        endcase
    end

    // Count and flags are registered together so the flags never glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            size  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            size  <= size_nxt;
            empty <= (size_nxt == '0);
            full  <= (size_nxt == SIZEW'(DEPTH));
        end
    end

endmodule

// File: rtl/rv_shift_fifo.sv
// Shift-register FIFO with a ready/valid read port.
// Writes shift into entry 0; the oldest entry sits at index size-1.
// Define RV_SHIFT_FIFO_BYPASS_EN to forward data_in straight to data_out
// while the FIFO is empty (zero-latency path); otherwise latency is 1 cycle.
module rv_shift_fifo
    import rv_shift_fifo_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int DEPTH = 4,
    parameter int SIZEW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out,
    output logic [SIZEW-1:0] size,
    output logic             empty,
    output logic             full
);

    localparam int IDXW = idx_width(DEPTH);

    logic [DATAW-1:0] entries [DEPTH];
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             cnt_pop;
    logic [IDXW-1:0]  rd_idx;
    logic [DATAW-1:0] head;

    // ready_in depends only on the registered full flag, never on ready_out.
    assign ready_in = ~full;
    assign push     = valid_in & ready_in;
    assign pop      = valid_out & ready_out;

    // Oldest entry lives at size-1. When empty, index 0 still holds the last
    // popped value (or zero after reset), so data_out keeps its last value.
    always_comb begin
        rd_idx = '0;
        if (!empty) begin
            rd_idx = IDXW'(size - SIZEW'(1));
        end
    end

    assign head = entries[rd_idx];

`ifdef RV_SHIFT_FIFO_BYPASS_EN
    assign valid_out = empty ? valid_in : 1'b1;
    assign data_out  = empty ? data_in : head;
    // A bypassed word consumed in the same cycle is never stored.
    assign wr_en     = push & ~(empty & pop);
    assign cnt_pop   = pop & ~empty;
`else
    assign valid_out = ~empty;
    assign data_out  = head;
    assign wr_en     = push;
    assign cnt_pop   = pop;
`endif

    // Entry array: every accepted write shifts the whole line by one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

    rv_shift_fifo_ctrl #(
        .DEPTH (DEPTH),
        .SIZEW (SIZEW)
    ) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (cnt_pop),
        .size  (size),
        .empty (empty),
        .full  (full)
    );

endmodule
